spi_master_engine: RTL and testbench
====================================

Name: spi_master_engine

Overview:
- Single-channel SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that sits directly downstream of the peripherals register block.
- Consumes the start, width and tx-buffer registers written by the CPU over the peripheral bus.
- Drives sclk/mosi to the external pins, samples miso, and returns the received word plus a busy flag for CPU readback.

Parameters:
- DIV_WIDTH, 4, width of the clock-divisor input; half-period of sclk = (divisor+1) raw_clk cycles.
- DATA_WIDTH, 16, maximum transfer length in bits; 8-bit mode uses the low byte.

Ports:
- raw_clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, level; accepted only in IDLE.
- width_16  input  1  1 = 16-bit transfer, 0 = 8-bit; latched at accept.
- divisor  input  DIV_WIDTH  sclk half-period minus one; latched at accept.
- data_tx  input  DATA_WIDTH  word to send; in 8-bit mode only [7:0] is sent; latched at accept.
- data_rx  output  DATA_WIDTH  last received word; in 8-bit mode [15:8] = 0.
- busy  output  1  high while a transfer is in progress.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Reset (async, any time including mid-transfer): state IDLE; sclk=0, mosi=0, busy=0, data_rx=0; bit and divider counters cleared. The partial transfer is discarded and data_rx is not updated.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - busy=0, sclk=0.
  - start=1 on edge k latches width_16, divisor and data_tx into a shift register.
  - Loads bit count N (8 or 16).
  - Drives mosi with the MSB (bit 7 or bit 15).
  - Moves to LOW; busy=1 from edge k.
- LOW: sclk=0 for divisor+1 cycles, then goes to HIGH.
- HIGH:
  - On entry, sclk=1 and miso is sampled into the rx shift register (shift left, LSB in).
  - Held for divisor+1 cycles.
  - On exit, if bits remain: shift the tx register, drive the next bit on mosi, go to LOW. mosi therefore changes only while sclk falls.
  - If the last bit is done: go to DONE.
- DONE:
  - One cycle, sclk=0, busy=1.
  - data_rx is loaded with the assembled word (zero-extended in 8-bit mode).
  - mosi returns to 0.
  - Next cycle: IDLE, busy=0.
- Busy duration: exactly N*2*(divisor+1)+1 cycles per transfer.
  - divisor=0, 8-bit: 17 cycles.
  - divisor=0, 16-bit: 33 cycles.
- busy is low for at least one cycle between transfers. If start is still high in IDLE, a new transfer is accepted: start is level-sensitive. The upstream block must deassert start once busy is seen.
- start, data_tx, width_16 and divisor changes during busy are ignored.
- divisor=max (15): half-period of 16 cycles; the divider counter must not overflow.
- data_rx is stable between DONE cycles and readable at any time.

Decomposition:
- Package spi_master_pkg:
  - state encoding (IDLE/LOW/HIGH/DONE, 2 bits)
  - constants BITS_8=8, BITS_16=16
  - DATA_WIDTH/DIV_WIDTH defaults
- Sub-module spi_half_period_timer:
  - loadable down-counter: load divisor, tick when zero
  - used by both LOW and HIGH
- All other logic (FSM, shift registers, bit counter) lives in the top module.

Test Plan:
- 8-bit, divisor=0, data_tx=16'h00A5, miso looped to mosi:
  - mosi shows 1,0,1,0,0,1,0,1 on 8 rising sclk edges.
  - busy is high exactly 17 cycles.
  - data_rx=16'h00A5.
- 16-bit, divisor=2, data_tx=16'hBEEF, miso tied 1:
  - sclk half-period 3 cycles, 16 pulses, busy 97 cycles.
  - data_rx=16'hFFFF.
  - mosi stable across every sclk rising edge.
- 8-bit, miso driven 8'h3C bit-serial MSB first, data_tx changed to 16'h0000 and divisor changed mid-transfer:
  - data_rx=16'h003C.
  - mosi sends the originally latched value.
  - timing is unchanged.
- start held high through two transfers (8-bit, divisor=0):
  - busy low exactly one cycle between transfers.
  - second transfer starts the following cycle.
- reset asserted asynchronously in the HIGH phase of bit 4 (data_rx previously 16'h0012):
  - sclk=0, mosi=0, busy=0 immediately.
  - data_rx=0.
  - the next start runs a full clean transfer.
- divisor=15, 8-bit:
  - each sclk level lasts 16 cycles.
  - busy lasts 257 cycles.
  - no divider wrap glitches.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared constants and state encoding for the SPI master engine.
package spi_master_pkg;

  localparam int unsigned DEF_DIV_WIDTH  = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  localparam int unsigned BITS_8  = 8;
  localparam int unsigned BITS_16 = 16;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t StIdle = 2'd0;
  localparam spi_state_t StLow  = 2'd1;
  localparam spi_state_t StHigh = 2'd2;
  localparam spi_state_t StDone = 2'd3;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter timing one sclk half-period; tick is high while the count is zero.
module spi_half_period_timer
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  // Reload on phase start; count down and park at zero so it never wraps.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= divisor;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master_engine.sv
// Mode-0 SPI master: MSB first, 8- or 16-bit transfers, programmable sclk half-period.
module spi_master_engine
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  raw_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  width_16,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [DATA_WIDTH-1:0] data_tx,
  output logic [DATA_WIDTH-1:0] data_rx,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  spi_state_t            state_q, state_d;
  logic                  width_q, width_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_rx_q, data_rx_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  mosi_q, mosi_d;

  logic                  in_phase;
  logic                  tmr_load;
  logic                  tick;
  logic [DIV_WIDTH-1:0]  tmr_div;

  assign in_phase = (state_q == StLow) || (state_q == StHigh);
  // The accept edge loads the live divisor; later phase reloads use the latched copy.
  assign tmr_load = ((state_q == StIdle) && start) || (in_phase && tick);
  assign tmr_div  = (state_q == StIdle) ? divisor : div_q;

  spi_half_period_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .raw_clk (raw_clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (in_phase),
    .divisor (tmr_div),
    .tick    (tick)
  );

  // Next-state: transfer sequencing, shift registers and bit counter.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    bit_cnt_d = bit_cnt_q;
    mosi_d    = mosi_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLow;
          width_d   = width_16;
          div_d     = divisor;
          rx_d      = '0;
          // 8-bit words are left-aligned so the MSB always leaves from the top bit.
          tx_d      = width_16 ? data_tx : {data_tx[BITS_8-1:0], {(DATA_WIDTH-BITS_8){1'b0}}};
          mosi_d    = width_16 ? data_tx[DATA_WIDTH-1] : data_tx[BITS_8-1];
          bit_cnt_d = width_16 ? CntW'(DATA_WIDTH) : CntW'(BITS_8);
        end
      end
      StLow: begin
        if (tick) begin
          state_d = StHigh;
          rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
        end
      end
      StHigh: begin
        if (tick) begin
          if (bit_cnt_q == CntW'(1)) begin
            state_d   = StDone;
            mosi_d    = 1'b0;
            data_rx_d = width_q ? rx_q : {{(DATA_WIDTH-BITS_8){1'b0}}, rx_q[BITS_8-1:0]};
          end else begin
            state_d   = StLow;
            bit_cnt_d = bit_cnt_q - CntW'(1);
            tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d    = tx_q[DATA_WIDTH-2];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset discards any partial transfer.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      width_q   <= 1'b0;
      div_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      bit_cnt_q <= '0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      bit_cnt_q <= bit_cnt_d;
      mosi_q    <= mosi_d;
    end
  end

  assign sclk    = (state_q == StHigh);
  assign busy    = (state_q != StIdle);
  assign mosi    = mosi_q;
  assign data_rx = data_rx_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: cycle-level reference model plus directed checks.
module tb_spi_master_engine;

  logic        raw_clk  = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic        width_16 = 1'b0;
  logic [3:0]  divisor  = '0;
  logic [15:0] data_tx  = '0;
  logic [15:0] data_rx;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;

  int n_tests = 0;
  int n_fail  = 0;

  // miso source: 0 = loopback from mosi, 1 = tied high, 2 = 8-bit pattern MSB first
  int          miso_mode = 0;
  logic [7:0]  pat8      = 8'h3C;
  int          pat_base  = 0;
  int          nrise     = 0;
  int          pidx;
  logic [15:0] cap       = '0;

  spi_master_engine #(
    .DIV_WIDTH  (4),
    .DATA_WIDTH (16)
  ) dut (
    .raw_clk  (raw_clk),
    .reset    (reset),
    .start    (start),
    .width_16 (width_16),
    .divisor  (divisor),
    .data_tx  (data_tx),
    .data_rx  (data_rx),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 raw_clk = ~raw_clk;

  always_comb begin
    pidx = nrise - pat_base;
    miso = 1'b0;
    case (miso_mode)
      0:       miso = mosi;
      1:       miso = 1'b1;
      default: miso = (pidx >= 0 && pidx < 8) ? pat8[7-pidx] : 1'b0;
    endcase
  end

  // Record mosi as seen by a slave at each rising sclk edge.
  always @(posedge sclk) begin
    cap   <= {cap[14:0], mosi};
    nrise <= nrise + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transfer is a timeline of T = N*2*(div+1)+1 busy cycles: for each bit a low then a
  // high half-period of div+1 cycles, then one closing cycle with sclk low.
  logic        m_act = 1'b0;
  int          m_off = 0;
  int          m_div = 0;
  int          m_n   = 8;
  int          m_t   = 17;
  logic        m_w16 = 1'b0;
  logic [15:0] m_tx  = '0;
  logic [15:0] m_sh  = '0;
  logic [15:0] m_rx  = '0;

  function automatic logic sclk_at(input int o, input int d, input int t);
    if (o >= t - 1) return 1'b0;
    return (o % (2 * (d + 1))) >= (d + 1);
  endfunction

  function automatic logic mosi_at(input int o, input int d, input int t, input int n,
                                   input logic [15:0] tx);
    int idx;
    if (o >= t - 1) return 1'b0;
    idx = n - 1 - o / (2 * (d + 1));
    return tx[idx];
  endfunction

  always @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0;
      m_off = 0;
      m_rx  = '0;
    end else if (m_act) begin
      if (m_off >= m_t - 1) begin
        m_act = 1'b0;
      end else begin
        if (!sclk_at(m_off, m_div, m_t) && sclk_at(m_off + 1, m_div, m_t))
          m_sh = {m_sh[14:0], miso};
        m_off++;
        if (m_off == m_t - 1) m_rx = m_w16 ? m_sh : {8'h00, m_sh[7:0]};
      end
    end else if (start) begin
      m_act = 1'b1;
      m_off = 0;
      m_w16 = width_16;
      m_div = int'(divisor);
      m_tx  = data_tx;
      m_n   = width_16 ? 16 : 8;
      m_t   = m_n * 2 * (m_div + 1) + 1;
      m_sh  = '0;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge raw_clk) begin
    check("model_busy", 32'(busy), 32'(m_act));
    check("model_sclk", 32'(sclk), 32'(m_act && sclk_at(m_off, m_div, m_t)));
    check("model_mosi", 32'(mosi), 32'(m_act && mosi_at(m_off, m_div, m_t, m_n, m_tx)));
    check("model_data_rx", 32'(data_rx), 32'(m_rx));
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input logic w16, input logic [3:0] div, input logic [15:0] tx,
                      output int bcyc);
    int guard;
    @(negedge raw_clk);
    width_16 = w16;
    divisor  = div;
    data_tx  = tx;
    start    = 1'b1;
    @(negedge raw_clk);
    guard = 0;
    while (!busy && guard < 10) begin
      @(negedge raw_clk);
      guard++;
    end
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    bcyc  = 0;
    guard = 0;
    while (busy && guard < 1000) begin
      bcyc++;
      @(negedge raw_clk);
      guard++;
    end
    check("busy_fall_timeout", 32'(guard < 1000), 32'd1);
  endtask

  initial begin
    int bc, b1, b2, lo, hi, g, base;
    #30000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, b1, b2, lo, hi, g, base;
    #1 reset = 1'b1;
    repeat (2) @(negedge raw_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_data_rx", 32'(data_rx), 32'd0);
    #1 reset = 1'b0;

    // 1: 8-bit, divisor 0, loopback
    miso_mode = 0;
    xfer(1'b0, 4'd0, 16'h00A5, bc);
    check("t1_busy_len", 32'(bc), 32'd17);
    check("t1_mosi_bits", 32'(cap[7:0]), 32'h0000_00A5);
    check("t1_data_rx", 32'(data_rx), 32'h0000_00A5);

    // 2: 16-bit, divisor 2, miso high
    miso_mode = 1;
    base = nrise;
    xfer(1'b1, 4'd2, 16'hBEEF, bc);
    check("t2_busy_len", 32'(bc), 32'd97);
    check("t2_pulses", 32'(nrise - base), 32'd16);
    check("t2_mosi_bits", 32'(cap), 32'h0000_BEEF);
    check("t2_data_rx", 32'(data_rx), 32'h0000_FFFF);

    // 3: 8-bit, divisor 1, pattern 3C on miso, inputs disturbed mid-transfer
    miso_mode = 2;
    pat_base  = nrise;
    fork
      xfer(1'b0, 4'd1, 16'h0069, bc);
      begin
        repeat (6) @(negedge raw_clk);
        data_tx  = 16'h0000;
        divisor  = 4'd7;
        width_16 = 1'b1;
      end
    join
    check("t3_busy_len", 32'(bc), 32'd33);
    check("t3_mosi_bits", 32'(cap[7:0]), 32'h0000_0069);
    check("t3_data_rx", 32'(data_rx), 32'h0000_003C);

    // 4: start held high across two transfers
    miso_mode = 0;
    @(negedge raw_clk);
    width_16 = 1'b0;
    divisor  = 4'd0;
    data_tx  = 16'h005A;
    start    = 1'b1;
    g = 0;
    @(negedge raw_clk);
    while (!busy && g < 10) begin @(negedge raw_clk); g++; end
    b1 = 0; g = 0;
    while (busy && g < 100) begin b1++; @(negedge raw_clk); g++; end
    lo = 0; g = 0;
    while (!busy && g < 100) begin lo++; @(negedge raw_clk); g++; end
    start = 1'b0;
    b2 = 0; g = 0;
    while (busy && g < 100) begin b2++; @(negedge raw_clk); g++; end
    check("t4_busy1_len", 32'(b1), 32'd17);
    check("t4_gap_len", 32'(lo), 32'd1);
    check("t4_busy2_len", 32'(b2), 32'd17);
    check("t4_data_rx", 32'(data_rx), 32'h0000_005A);

    // 5: async reset during the high phase of bit 4
    xfer(1'b0, 4'd0, 16'h0012, bc);
    check("t5_pre_data_rx", 32'(data_rx), 32'h0000_0012);
    base = nrise;
    @(negedge raw_clk);
    data_tx = 16'h00C3;
    start   = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
    g = 0;
    while ((nrise - base) < 5 && g < 100) begin @(negedge raw_clk); g++; end
    check("t5_in_high", 32'(sclk), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_sclk", 32'(sclk), 32'd0);
    check("t5_rst_mosi", 32'(mosi), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data_rx", 32'(data_rx), 32'd0);
    @(negedge raw_clk);
    #1 reset = 1'b0;
    xfer(1'b0, 4'd0, 16'h0096, bc);
    check("t5_busy_len", 32'(bc), 32'd17);
    check("t5_data_rx", 32'(data_rx), 32'h0000_0096);

    // 6: divisor at maximum
    fork
      xfer(1'b0, 4'd15, 16'h00E1, bc);
      begin
        g = 0;
        while (!busy && g < 20) begin @(negedge raw_clk); g++; end
        lo = 0; g = 0;
        while (!sclk && g < 100) begin lo++; @(negedge raw_clk); g++; end
        hi = 0; g = 0;
        while (sclk && g < 100) begin hi++; @(negedge raw_clk); g++; end
      end
    join
    check("t6_low_len", 32'(lo), 32'd16);
    check("t6_high_len", 32'(hi), 32'd16);
    check("t6_busy_len", 32'(bc), 32'd257);
    check("t6_data_rx", 32'(data_rx), 32'h0000_00E1);

    repeat (3) @(negedge raw_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
